led_char_decoder: RTL and testbench

//  Maps a 4-bit character code to the seven segment drive pattern (a..g).
//  It sits inside the four-digit LED display driver. The driver loads `char`
//  and, at least two display-state ticks later, samples `LED` onto pins a..g.
//  The output is registered: one clock of latency, glitch-free segment lines.

---
 rtl/led_pkg.sv | 58 +++++
 rtl/led_char_decoder_if.sv | 10 +
 rtl/led_char_decoder.sv | 32 +++
 tb/tb_led_char_decoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared seven-segment constants and the character lookup table.
// Patterns are active-low, bit order abcdefg (bit 6 = a, bit 0 = g).
package led_pkg;

   localparam int unsigned SEG_A_IDX = 6;
   localparam int unsigned SEG_B_IDX = 5;
   localparam int unsigned SEG_C_IDX = 4;
   localparam int unsigned SEG_D_IDX = 3;
   localparam int unsigned SEG_E_IDX = 2;
   localparam int unsigned SEG_F_IDX = 1;
   localparam int unsigned SEG_G_IDX = 0;

   localparam logic [3:0] CHAR_BLANK = 4'hF;
   localparam logic [6:0] SEG_BLANK  = 7'b1111111;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;

   // Unknown code bits match no item and fall to the blank default.
   function automatic logic [6:0] seg_lookup(logic [3:0] code);
      logic [6:0] seg;
      seg = SEG_BLANK;
      case (code)
         4'h0:       seg = SEG_0;
         4'h1:       seg = SEG_1;
         4'h2:       seg = SEG_2;
         4'h3:       seg = SEG_3;
         4'h4:       seg = SEG_4;
         4'h5:       seg = SEG_5;
         4'h6:       seg = SEG_6;
         4'h7:       seg = SEG_7;
         4'h8:       seg = SEG_8;
         4'h9:       seg = SEG_9;
         4'hA:       seg = SEG_A;
         4'hB:       seg = SEG_B;
         4'hC:       seg = SEG_C;
         4'hD:       seg = SEG_D;
         4'hE:       seg = SEG_E;
         CHAR_BLANK: seg = SEG_BLANK;
         default:    seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/led_char_decoder_if.sv
// Character-in / segments-out bundle between the display driver and the decoder.
interface led_char_decoder_if;

   logic [3:0] char;
   logic [6:0] LED;

   modport master (output char, input LED);
   modport slave  (input char, output LED);

endinterface

// File: rtl/led_char_decoder.sv
// Registered 4-bit character to seven-segment decoder; one clock of latency.
module led_char_decoder
   import led_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   led_char_decoder_if.slave bus
);

   // Polarity flip applies to every entry, the reset value included.
   localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'b0000000 : 7'b1111111;

   logic [6:0] led_d;
   logic [6:0] led_q;

   always_comb begin
      led_d = seg_lookup(bus.char) ^ SEG_MASK;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q <= SEG_BLANK ^ SEG_MASK;
      end else begin
         led_q <= led_d;
      end
   end

   assign bus.LED = led_q;

endmodule

// File: tb/tb_led_char_decoder.sv
// Scoreboard bench for led_char_decoder: active-low and inverted-polarity instances.
module tb_led_char_decoder;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   led_char_decoder_if bus_lo ();
   led_char_decoder_if bus_hi ();

   led_char_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_lo.slave)
   );

   led_char_decoder #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_hi.slave)
   );

   typedef struct {
      int unsigned inst;
      logic [6:0]  exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Hand-entered active-low table, abcdefg.
   localparam logic [6:0] TBL [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b1111111
   };

   function automatic logic [6:0] exp_of(logic [3:0] c, bit active_low);
      logic [6:0] e;
      if ($isunknown(c)) e = 7'b1111111;
      else               e = TBL[c];
      return active_low ? e : ~e;
   endfunction

   task automatic check(string name, logic [6:0] act, logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push(int unsigned inst, logic [3:0] c, string name);
      exp_t e;
      e.inst = inst;
      e.exp  = exp_of(c, inst == 0);
      e.name = name;
      sb.push_back(e);
   endfunction

   // Monitor: every expectation pushed before an edge is due on that edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         check(e.name, (e.inst == 0) ? bus_lo.LED : bus_hi.LED, e.exp);
      end
   end

   initial begin
      reset       = 1'b0;
      bus_lo.char = 4'h8;
      bus_hi.char = 4'h8;

      repeat (3) begin
         @(negedge clk);
         check("reset_hold", bus_lo.LED, 7'b1111111);
         check("reset_hold_inv", bus_hi.LED, 7'b0000000);
      end

      @(negedge clk);
      reset = 1'b1;
      push(0, bus_lo.char, "post_reset");
      push(1, bus_hi.char, "post_reset_inv");

      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         bus_lo.char = 4'(c);
         push(0, bus_lo.char, $sformatf("sweep_%0h", c));
      end

      // Mid-cycle change must not reach LED before the next edge.
      @(negedge clk);
      bus_lo.char = 4'h1;
      push(0, bus_lo.char, "latency_1");
      @(negedge clk);
      bus_lo.char = 4'h7;
      #1;
      check("latency_hold", bus_lo.LED, 7'b1001111);
      push(0, bus_lo.char, "latency_7");

      @(negedge clk);
      bus_lo.char = 4'h0;
      push(0, bus_lo.char, "pre_async");
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", bus_lo.LED, 7'b1111111);
      check("async_reset_inv", bus_hi.LED, 7'b0000000);
      @(negedge clk);
      reset = 1'b1;
      push(0, bus_lo.char, "first_after_async");
      push(1, bus_hi.char, "first_after_async_inv");

      @(negedge clk);
      bus_lo.char = 4'bx1x0;
      push(0, bus_lo.char, "x_input");
      @(negedge clk);
      bus_lo.char = 4'h3;
      push(0, bus_lo.char, "after_x");

      @(negedge clk);
      bus_hi.char = 4'h1;
      push(1, bus_hi.char, "inv_char1");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("inv_reset", bus_hi.LED, 7'b0000000);
      check("lo_reset_again", bus_lo.LED, 7'b1111111);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
